// File: rtl/bitonic_iter_sort8.sv
`default_nettype none
// ============================================================================
// Module   : bitonic_iter_sort8
// Purpose  : Iterative 8-element bitonic sorter. A vector is loaded, then one
//            network stage is applied per clock using four shared
//            compare-exchange units. The six-stage result is held until the
//            consumer accepts it.
// Ports    : clk        - clock, rising edge
//            rst        - asynchronous active-high reset
//            in_valid   - input vector offered
//            in_ready   - block can accept a vector (IDLE only)
//            in_data    - 8 x W-bit elements, element e at [e*W +: W]
//            in_desc    - 0 = ascending, 1 = descending, sampled with in_data
//            out_valid  - sorted vector available (DONE only)
//            out_ready  - consumer accepts the vector
//            out_data   - sorted elements, same packing as in_data
// Revision : 1.0 - initial release
// ============================================================================
module bitonic_iter_sort8 #(
    parameter int W = 8
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [8*W-1:0] in_data,
    input  logic           in_desc,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [8*W-1:0] out_data
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SORT = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [2:0] c_last_stage = 3'd5;

    state_t         r_state;
    state_t         w_state_nxt;
    logic [2:0]     r_stage;
    logic           r_desc;
    logic [W-1:0]   r_elem     [8];
    logic [W-1:0]   w_elem_nxt [8];
    logic           w_load;
    logic           w_step;

    // Stage parameters (k,j) for the current counter value.
    logic [3:0]     w_k;
    logic [2:0]     w_j;

    // Per-unit compare-exchange results, packed per unit.
    logic [4*3-1:0] w_lo_idx;
    logic [4*3-1:0] w_hi_idx;
    logic [4*W-1:0] w_lo_val;
    logic [4*W-1:0] w_hi_val;

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state and handshake outputs
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        w_load      = 1'b0;
        w_step      = 1'b0;
        case (r_state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    w_load      = 1'b1;
                    w_state_nxt = SORT;
                end
            end
            SORT: begin
                w_step = 1'b1;
                if (r_stage == c_last_stage) begin
                    w_state_nxt = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Stage schedule: (2,1) (4,2) (4,1) (8,4) (8,2) (8,1)
    // ------------------------------------------------------------------
    always_comb begin
        w_k = 4'd8;
        w_j = 3'd1;
        case (r_stage)
            3'd0:    begin w_k = 4'd2; w_j = 3'd1; end
            3'd1:    begin w_k = 4'd4; w_j = 3'd2; end
            3'd2:    begin w_k = 4'd4; w_j = 3'd1; end
            3'd3:    begin w_k = 4'd8; w_j = 3'd4; end
            3'd4:    begin w_k = 4'd8; w_j = 3'd2; end
            default: begin w_k = 4'd8; w_j = 3'd1; end
        endcase
    end

    // ------------------------------------------------------------------
    // Four shared compare-exchange units. Every stage has exactly four
    // pairs (i, i^j) with bit j of i clear; unit u takes the u-th such i,
    // obtained by inserting a zero into u at the bit position of j.
    // ------------------------------------------------------------------
    for (genvar u = 0; u < 4; u++) begin : g_cx
        localparam logic [1:0] c_u = 2'(u);

        logic [2:0]   w_lo;
        logic [2:0]   w_hi;
        logic [W-1:0] w_a;
        logic [W-1:0] w_b;
        logic         w_asc;
        logic         w_swap;

        assign w_lo = (w_j == 3'd1) ? {c_u, 1'b0} :
                      (w_j == 3'd2) ? {c_u[1], 1'b0, c_u[0]} :
                                      {1'b0, c_u};
        assign w_hi = w_lo | w_j;

        assign w_a  = r_elem[w_lo];
        assign w_b  = r_elem[w_hi];

        assign w_asc  = (({1'b0, w_lo} & w_k) == 4'd0) ^ r_desc;
        // Strict compares so that equal elements are never swapped.
        assign w_swap = w_asc ? (w_a > w_b) : (w_a < w_b);

        assign w_lo_idx[u*3 +: 3] = w_lo;
        assign w_hi_idx[u*3 +: 3] = w_hi;
        assign w_lo_val[u*W +: W] = w_swap ? w_b : w_a;
        assign w_hi_val[u*W +: W] = w_swap ? w_a : w_b;
    end

    // The four pairs of a stage are disjoint and cover all eight elements.
    always_comb begin
        w_elem_nxt = r_elem;
        for (int u = 0; u < 4; u++) begin
            w_elem_nxt[w_lo_idx[u*3 +: 3]] = w_lo_val[u*W +: W];
            w_elem_nxt[w_hi_idx[u*3 +: 3]] = w_hi_val[u*W +: W];
        end
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stage <= 3'd0;
            r_desc  <= 1'b0;
            for (int e = 0; e < 8; e++) begin
                r_elem[e] <= '0;
            end
        end else if (w_load) begin
            r_stage <= 3'd0;
            r_desc  <= in_desc;
            for (int e = 0; e < 8; e++) begin
                r_elem[e] <= in_data[e*W +: W];
            end
        end else if (w_step) begin
            r_stage <= r_stage + 3'd1;
            r_elem  <= w_elem_nxt;
        end
    end

    for (genvar e = 0; e < 8; e++) begin : g_pack
        assign out_data[e*W +: W] = r_elem[e];
    end

endmodule
`default_nettype wire
